// File: rtl/calc_result_display_pkg.sv
// Shared types and constants for the calculator result display: FSM encoding,
// double-dabble shift count and active-low seven-segment glyphs (gfedcba).
package calc_result_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } conv_state_e;

  localparam int unsigned ShiftCount = 16;
  localparam int unsigned CntW       = $clog2(ShiftCount + 1);

  localparam logic [6:0] Seg0     = 7'h40;
  localparam logic [6:0] Seg1     = 7'h79;
  localparam logic [6:0] Seg2     = 7'h24;
  localparam logic [6:0] Seg3     = 7'h30;
  localparam logic [6:0] Seg4     = 7'h19;
  localparam logic [6:0] Seg5     = 7'h12;
  localparam logic [6:0] Seg6     = 7'h02;
  localparam logic [6:0] Seg7     = 7'h78;
  localparam logic [6:0] Seg8     = 7'h00;
  localparam logic [6:0] Seg9     = 7'h10;
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegE     = 7'h06;
  localparam logic [6:0] SegF     = 7'h0E;

  // A-F never come out of the BCD engine but are decoded anyway.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SegBlank;
    unique case (nib)
      4'h0: seg = Seg0;
      4'h1: seg = Seg1;
      4'h2: seg = Seg2;
      4'h3: seg = Seg3;
      4'h4: seg = Seg4;
      4'h5: seg = Seg5;
      4'h6: seg = Seg6;
      4'h7: seg = Seg7;
      4'h8: seg = Seg8;
      4'h9: seg = Seg9;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = SegE;
      4'hF: seg = SegF;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// Result bus between the calculator core (master) and the result display (slave).
interface calc_result_display_if;
  logic [15:0] Value;
  logic        Load;
  logic        Flag;
  logic        Err;
  logic        Busy;
  logic [19:0] Bcd;

  modport master (output Value, Load, Flag, Err, input Busy, Bcd);
  modport slave (input Value, Load, Flag, Err, output Busy, Bcd);
endinterface

// File: rtl/calc_result_display_bin16_to_bcd5.sv
// Sequential double-dabble engine: 16-bit binary to 5 BCD nibbles, one shift per cycle.
// Start is only honoured in idle; Done is high for the single cycle the result is final.
module calc_result_display_bin16_to_bcd5
  import calc_result_display_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic [19:0] Result
);

  conv_state_e     state_q, state_d;
  logic [15:0]     shift_q, shift_d;
  logic [19:0]     work_q, work_d, work_adj;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Nibble corrections are independent 4-bit adds on the pre-shift value.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 5; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          shift_d = Value;
          work_d  = '0;
          cnt_d   = CntW'(ShiftCount);
          state_d = StConv;
        end
      end
      StConv: begin
        {work_d, shift_d} = {work_adj[18:0], shift_q, 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy   = (state_q != StIdle);
  assign Done   = (state_q == StDone);
  assign Result = work_q;

endmodule

// File: rtl/calc_result_display.sv
// Calculator result display: BCD conversion of the result bus and an 8-digit multiplexed
// active-low seven-segment scan. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module calc_result_display
  import calc_result_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W = 18
) (
  input  logic                  Clk,
  input  logic                  Reset,
  calc_result_display_if.slave  bus,
  output logic [7:0]            An,
  output logic [6:0]            Seg,
  output logic                  Dp
);

  logic        eng_busy, eng_done;
  logic [19:0] eng_result;
  logic        load_acc;

  logic [19:0] bcd_q;
  logic        pend_flag_q, pend_err_q;
  logic        disp_flag_q, disp_err_q;

  logic [SCAN_DIV_W-1:0] scan_q;
  logic [2:0]            digit_idx;
  logic [3:0]            digit_nib;
  logic                  digit_num;
  logic [7:0]            zero_blank;
  logic [7:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  calc_result_display_bin16_to_bcd5 u_bcd (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (bus.Load),
    .Value  (bus.Value),
    .Busy   (eng_busy),
    .Done   (eng_done),
    .Result (eng_result)
  );

  assign load_acc = bus.Load && !eng_busy;

  // Bcd and the indicator latches change only on completion, so the display never
  // shows a half-converted value.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bcd_q       <= '0;
      pend_flag_q <= 1'b0;
      pend_err_q  <= 1'b0;
      disp_flag_q <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      if (load_acc) begin
        pend_flag_q <= bus.Flag;
        pend_err_q  <= bus.Err;
      end
      if (eng_done) begin
        bcd_q       <= eng_result;
        disp_flag_q <= pend_flag_q;
        disp_err_q  <= pend_err_q;
      end
    end
  end

  assign bus.Busy  = eng_busy;
  assign bus.Bcd   = bcd_q;
  assign digit_idx = scan_q[SCAN_DIV_W-1 -: 3];

  always_comb begin
    zero_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    zero_blank[4] = (bcd_q[19:16] == 4'h0);
    zero_blank[3] = zero_blank[4] && (bcd_q[15:12] == 4'h0);
    zero_blank[2] = zero_blank[3] && (bcd_q[11:8] == 4'h0);
    zero_blank[1] = zero_blank[2] && (bcd_q[7:4] == 4'h0);
`else
    zero_blank = '0;
`endif

    digit_nib = 4'h0;
    digit_num = 1'b0;
    unique case (digit_idx)
      3'd0: begin digit_nib = bcd_q[3:0];   digit_num = 1'b1; end
      3'd1: begin digit_nib = bcd_q[7:4];   digit_num = 1'b1; end
      3'd2: begin digit_nib = bcd_q[11:8];  digit_num = 1'b1; end
      3'd3: begin digit_nib = bcd_q[15:12]; digit_num = 1'b1; end
      3'd4: begin digit_nib = bcd_q[19:16]; digit_num = 1'b1; end
      default: ;
    endcase

    an_d  = ~(8'b1 << digit_idx);
    seg_d = SegBlank;
    dp_d  = 1'b1;
    if (digit_num) begin
      if (!disp_err_q && !zero_blank[digit_idx]) seg_d = hex_to_seg(digit_nib);
    end else if (digit_idx == 3'd7) begin
      if (disp_err_q)       seg_d = SegE;
      else if (disp_flag_q) seg_d = SegF;
    end
    if (digit_idx == 3'd0 && disp_flag_q && !disp_err_q) dp_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scan_q <= '0;
      an_q   <= 8'hFF;
      seg_q  <= SegBlank;
      dp_q   <= 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = dp_q;

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Output-side consumer of the calculator's 16-bit result bus, result-valid pulse, overflow flag and error indication.
- Converts the unsigned binary result to 5 BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed 8-digit, active-low seven-segment display.
- Sits between the calculator core and the board display pins.

Parameters:
SCAN_DIV_W, 18, width of the free-running refresh counter; top 3 bits select the digit, so each digit is held for 2^(SCAN_DIV_W-3) cycles.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Value  input  16  unsigned result to display.
Load  input  1  one-cycle pulse; samples Value, Flag and Err and starts a conversion.
Flag  input  1  overflow indication, sampled with Load.
Err  input  1  error indication (e.g. divide by zero), sampled with Load.
Busy  output  1  high while a conversion is in progress.
Bcd  output  20  last completed result, 5 BCD nibbles, [3:0] is the units digit.
An  output  8  digit anodes, active-low, one-hot-low.
Seg  output  7  segments gfedcba, active-low.
Dp  output  1  decimal point, active-low.

Behaviour:
- Reset asserted (Reset=0), asynchronous, including mid-conversion:
  - Busy=0, Bcd=0, An=8'hFF, Seg=7'h7F, Dp=1.
  - Latched flag and error = 0; refresh counter = 0; FSM = IDLE.
  - Any in-progress conversion is discarded.
- FSM states: IDLE, CONV, DONE.
- IDLE, Load=1:
  - Shift register <= Value; working BCD <= 0; bit counter <= 16.
  - Pending flag/error <= Flag/Err; go to CONV.
  - Busy=1 from the next cycle.
- CONV, each cycle:
  - Every working nibble >=5 gets +3 (corrections applied in parallel on the pre-shift value).
  - Then {BCD, shift} shifts left by 1; counter decrements.
  - When the counter reaches 0 after the 16th shift, go to DONE.
- DONE, one cycle:
  - Bcd <= working BCD; displayed flag/error <= pending; Busy <= 0; go to IDLE.
- Latency:
  - Load sampled at edge 0; Busy high for 17 cycles (16 CONV + 1 DONE).
  - Bcd and the display update at edge 17.
  - A new Load is accepted at edge 18 at the earliest.
- Load while Busy=1 is ignored; no queueing, and the in-flight conversion is unaffected.
- Load and Reset deasserting in the same cycle: Load is not accepted.
- Display shows the previous Bcd until DONE, so there is no partial-value flicker.
- Arithmetic:
  - Working BCD is 20 bits; maximum input 65535 gives 0x65535, so no overflow is possible.
  - Correction adds are 4-bit with no carry between nibbles.
- Refresh:
  - Free-running SCAN_DIV_W-bit counter that wraps; the digit index is the top 3 bits.
  - An, Seg and Dp are registered, giving one cycle of latency from the digit index.
- Digit content:
  - Digits 0-4: hex-to-7seg of the Bcd nibble; digits 5-6: blank (Seg=7'h7F).
  - Digit 7: error latched -> 'E' (Seg=7'h06); else flag latched -> 'F' (7'h0E); else blank.
  - Error latched: digits 0-4 blank.
  - Flag latched and error clear: Dp=0 on digit 0; Dp=1 otherwise.
- Non-decimal nibbles cannot occur; the decoder still maps A-F for robustness.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits 4 down to 1 are blanked while they and all higher digits are zero; digit 0 is always shown, so value 0 displays a single "0".
- Undefined: all five digits are shown with zeros, e.g. "00042".
- The macro does not affect Bcd or Busy timing.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE/CONV/DONE).
  - Seven-segment glyph constants: digits 0-9, SEG_BLANK=7'h7F, SEG_E=7'h06, SEG_F=7'h0E.
  - The 16 shift-count constant.
- One sub-module: bin16_to_bcd5, the double-dabble engine with Start/Busy/Done handshake.
- Scan mux and decoder stay in the top module.

Test Plan:
- Load Value=16'd1234 -> Busy high exactly 17 cycles, then Bcd=20'h01234 and Busy=0.
- Load 16'd65535, then 16'd0 -> Bcd=20'h65535, then 20'h00000; no X on any output.
- Load 100; pulse Load=1 with Value=9 five cycles later -> second Load ignored, Bcd=20'h00100.
- SCAN_DIV_W=6, Load 42 with Flag=1 -> digit 0 shows '2' with Dp=0, digit 7 Seg=7'h0E, each An low for 8 cycles in rotation.
  - With the macro defined, digits 2-4 are blank; without it, Seg shows '0' on those digits.
- Load with Err=1 -> digit 7 Seg=7'h06, digits 0-4 Seg=7'h7F; next Load with Err=0 clears it.
- Reset low at cycle 8 of a conversion -> outputs return to reset values immediately; after release, a Load of 7 converts correctly to Bcd=20'h00007.
